uart_tx_feeder: RTL

//  Upstream feeder for the UART transmit state machine. Buffers host bytes in a

---
 rtl/uart_tx_feeder.sv | 123 ++++++++++++
 1 files changed

// File: rtl/uart_tx_feeder.sv
// Byte FIFO in front of the UART transmit state machine: pops one byte into the
// transmit holding register, requests a start, then waits for a rising txd_done.
module uart_tx_feeder #(
    parameter int unsigned DATA_BITS  = 8,
    parameter int unsigned DEPTH_LOG2 = 2
) (
    input  logic                  bclk,
    input  logic                  rst_n,
    input  logic                  wr_en,
    input  logic [DATA_BITS-1:0]  wr_data,
    input  logic                  clr_ovf,
    input  logic                  txd_done,
    output logic                  txd_startH,
    output logic [DATA_BITS-1:0]  thr_data,
    output logic                  full,
    output logic                  empty,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  busy,
    output logic                  overflow
);

    localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
    localparam int unsigned CW    = DEPTH_LOG2 + 1;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_START = 2'd1;
    localparam logic [1:0] ST_BUSY  = 2'd2;

    logic [DATA_BITS-1:0]  mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [1:0]            state;
    logic [1:0]            state_nxt;
    logic                  txd_done_q;
    logic                  done_rise;
    logic                  pop;
    logic                  wr_acc;
    logic                  ovf_set;
    logic                  busy_nxt;
    logic [CW-1:0]         count_nxt;

    // Next-state decode; only a rising edge of txd_done, seen in BUSY, ends a frame.
    always_comb begin
        state_nxt = state;
        pop       = 1'b0;
        busy_nxt  = busy;
        done_rise = txd_done & ~txd_done_q;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    pop       = 1'b1;
                    state_nxt = ST_START;
                    busy_nxt  = 1'b1;
                end
            end
            ST_START: state_nxt = ST_BUSY;
            ST_BUSY: begin
                if (done_rise) begin
                    state_nxt = ST_IDLE;
                    busy_nxt  = 1'b0;
                end
            end
            default: begin
                state_nxt = ST_IDLE;
                busy_nxt  = 1'b0;
            end
        endcase
        wr_acc    = wr_en && (!full || pop);
        ovf_set   = wr_en && full && !pop;
        count_nxt = count + CW'(wr_acc) - CW'(pop);
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Storage array carries no reset; pointers define what is valid.
    always_ff @(posedge bclk) begin
        if (wr_acc) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge bclk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            count      <= '0;
            full       <= 1'b0;
            empty      <= 1'b1;
            txd_startH <= 1'b0;
            thr_data   <= '0;
            busy       <= 1'b0;
            overflow   <= 1'b0;
            txd_done_q <= 1'b0;
        end else begin
            txd_done_q <= txd_done;
            count      <= count_nxt;
            full       <= (count_nxt == CW'(DEPTH));
            empty      <= (count_nxt == '0);
            busy       <= busy_nxt;
            txd_startH <= (state_nxt == ST_START);
            if (wr_acc) begin
                wr_ptr <= wr_ptr + DEPTH_LOG2'(1);
            end
            if (pop) begin
                rd_ptr   <= rd_ptr + DEPTH_LOG2'(1);
                thr_data <= mem[rd_ptr];
            end
            // A new overflow beats a simultaneous clear.
            if (ovf_set) begin
                overflow <= 1'b1;
            end else if (clr_ovf) begin
                overflow <= 1'b0;
            end
        end
    end

endmodule
